// File: rtl/frame_buffer_window_reader.sv
// frame_buffer_window_reader: sweeps the columns of a 3-row frame buffer,
// assembles 3x3 pixel windows and hands them out over valid/ready.
// Ports:
//   I_CLK, I_RESET            clock, synchronous active-high reset
//   I_START, I_TOP_ROW        start a sweep, buffer row used as window row 0
//   O_COLUMN, O_ROW           frame buffer read address
//   O_READ_ENABLE, I_PIXEL    read strobe, read data (one cycle latency)
//   O_WINDOW                  3x3 window, element 3*r+c at [k*DEPTH +: DEPTH]
//   O_CENTER_COLUMN           buffer column of the window centre
//   O_WINDOW_VALID            window available
//   I_WINDOW_READY            consumer accepts the window
//   O_BUSY, O_DONE            sweep in progress, end-of-sweep pulse
module frame_buffer_window_reader #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic                           I_START,
    input  logic [$clog2(P_ROWS)-1:0]      I_TOP_ROW,
    output logic [$clog2(P_COLUMNS)-1:0]   O_COLUMN,
    output logic [$clog2(P_ROWS)-1:0]      O_ROW,
    output logic                           O_READ_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
    output logic [9*P_PIXEL_DEPTH-1:0]     O_WINDOW,
    output logic [$clog2(P_COLUMNS)-1:0]   O_CENTER_COLUMN,
    output logic                           O_WINDOW_VALID,
    input  logic                           I_WINDOW_READY,
    output logic                           O_BUSY,
    output logic                           O_DONE
);

    localparam int CW = $clog2(P_COLUMNS);
    localparam int RW = $clog2(P_ROWS);
    localparam int PW = P_PIXEL_DEPTH;
    localparam logic [CW-1:0] LAST_COL = CW'(P_COLUMNS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(P_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_CAP,
        S_EMIT,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [RW-1:0] top, top_nx;
    logic [CW-1:0] col_nx;
    logic [RW-1:0] row_nx;
    logic          rd_en_nx;
    logic [CW-1:0] center_nx;
    logic          valid_nx;
    logic          busy_nx;
    logic          done_nx;
    logic [PW-1:0] pix0, pix1;

    function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
        return (r == LAST_ROW) ? '0 : r + RW'(1);
    endfunction

    // Outputs are registered, so the comb block computes their values
    // for the state being entered.
    always_comb begin
        state_nx  = state;
        top_nx    = top;
        col_nx    = O_COLUMN;
        row_nx    = O_ROW;
        center_nx = O_CENTER_COLUMN;
        valid_nx  = O_WINDOW_VALID;

        unique case (state)
            S_IDLE: begin
                if (I_START) begin
                    top_nx   = (int'(I_TOP_ROW) >= P_ROWS) ? '0 : I_TOP_ROW;
                    col_nx   = '0;
                    state_nx = S_RD0;
                end
            end
            S_RD0: state_nx = S_RD1;
            S_RD1: state_nx = S_RD2;
            S_RD2: state_nx = S_CAP;
            S_CAP: begin
                // The first two columns only prime the window.
                if (O_COLUMN >= CW'(2)) begin
                    valid_nx  = 1'b1;
                    center_nx = O_COLUMN - CW'(1);
                    state_nx  = S_EMIT;
                end else begin
                    col_nx   = O_COLUMN + CW'(1);
                    state_nx = S_RD0;
                end
            end
            S_EMIT: begin
                if (I_WINDOW_READY) begin
                    valid_nx = 1'b0;
                    if (O_COLUMN == LAST_COL) begin
                        state_nx = S_FIN;
                    end else begin
                        col_nx   = O_COLUMN + CW'(1);
                        state_nx = S_RD0;
                    end
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        unique case (state_nx)
            S_RD0:   row_nx = top_nx;
            S_RD1:   row_nx = row_inc(top_nx);
            S_RD2:   row_nx = row_inc(row_inc(top_nx));
            default: row_nx = O_ROW;
        endcase

        rd_en_nx = (state_nx == S_RD0) || (state_nx == S_RD1)
                || (state_nx == S_RD2);
        busy_nx  = (state_nx != S_IDLE) && (state_nx != S_FIN);
        done_nx  = (state_nx == S_FIN);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state           <= S_IDLE;
            top             <= '0;
            O_COLUMN        <= '0;
            O_ROW           <= '0;
            O_READ_ENABLE   <= 1'b0;
            O_CENTER_COLUMN <= '0;
            O_WINDOW_VALID  <= 1'b0;
            O_BUSY          <= 1'b0;
            O_DONE          <= 1'b0;
            O_WINDOW        <= '0;
            pix0            <= '0;
            pix1            <= '0;
        end else begin
            state           <= state_nx;
            top             <= top_nx;
            O_COLUMN        <= col_nx;
            O_ROW           <= row_nx;
            O_READ_ENABLE   <= rd_en_nx;
            O_CENTER_COLUMN <= center_nx;
            O_WINDOW_VALID  <= valid_nx;
            O_BUSY          <= busy_nx;
            O_DONE          <= done_nx;

            // Read data lags the strobe by one state: RD1 sees row 0,
            // RD2 sees row 1 and CAP sees row 2.
            if (state == S_RD1) begin
                pix0 <= I_PIXEL;
            end
            if (state == S_RD2) begin
                pix1 <= I_PIXEL;
            end
            if (state == S_CAP) begin
                O_WINDOW[0*PW +: PW] <= O_WINDOW[1*PW +: PW];
                O_WINDOW[1*PW +: PW] <= O_WINDOW[2*PW +: PW];
                O_WINDOW[2*PW +: PW] <= pix0;
                O_WINDOW[3*PW +: PW] <= O_WINDOW[4*PW +: PW];
                O_WINDOW[4*PW +: PW] <= O_WINDOW[5*PW +: PW];
                O_WINDOW[5*PW +: PW] <= pix1;
                O_WINDOW[6*PW +: PW] <= O_WINDOW[7*PW +: PW];
                O_WINDOW[7*PW +: PW] <= O_WINDOW[8*PW +: PW];
                O_WINDOW[8*PW +: PW] <= I_PIXEL;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_window_reader.sv
// tb_frame_buffer_window_reader: directed bench for the window reader,
// with behavioural frame buffers returning pixel = {row, column}.
module tb_frame_buffer_window_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   top_row;
    logic [2:0]   column;
    logic [1:0]   row;
    logic         rd_en;
    logic [23:0]  pixel = '0;
    logic [215:0] window;
    logic [2:0]   center;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         done;

    logic         w_start;
    logic [1:0]   w_top_row;
    logic [9:0]   w_column;
    logic [1:0]   w_row;
    logic         w_rd_en;
    logic [23:0]  w_pixel = '0;
    logic [215:0] w_window;
    logic [9:0]   w_center;
    logic         w_valid;
    logic         w_ready;
    logic         w_busy;
    logic         w_done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_buffer_window_reader #(
        .P_COLUMNS(8), .P_ROWS(3), .P_PIXEL_DEPTH(24)
    ) dut (
        .I_CLK(clk), .I_RESET(rst), .I_START(start),
        .I_TOP_ROW(top_row), .O_COLUMN(column), .O_ROW(row),
        .O_READ_ENABLE(rd_en), .I_PIXEL(pixel), .O_WINDOW(window),
        .O_CENTER_COLUMN(center), .O_WINDOW_VALID(valid),
        .I_WINDOW_READY(ready), .O_BUSY(busy), .O_DONE(done)
    );

    frame_buffer_window_reader #(
        .P_COLUMNS(640), .P_ROWS(3), .P_PIXEL_DEPTH(24)
    ) dut_w (
        .I_CLK(clk), .I_RESET(rst), .I_START(w_start),
        .I_TOP_ROW(w_top_row), .O_COLUMN(w_column), .O_ROW(w_row),
        .O_READ_ENABLE(w_rd_en), .I_PIXEL(w_pixel), .O_WINDOW(w_window),
        .O_CENTER_COLUMN(w_center), .O_WINDOW_VALID(w_valid),
        .I_WINDOW_READY(w_ready), .O_BUSY(w_busy), .O_DONE(w_done)
    );

    function automatic logic [23:0] pix(input int r, input int c);
        return {r[7:0], c[15:0]};
    endfunction

    always @(posedge clk) begin
        if (rd_en) pixel <= pix(int'(row), int'(column));
        if (w_rd_en) w_pixel <= pix(int'(w_row), int'(w_column));
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sweep of the 8-column instance. The second window can be
    // stalled for stall_len cycles; start is pulsed at busy_edge.
    task automatic sweep(input int t, input int stall_len,
                         input int busy_edge);
        int e, rd_i, nwin, ndone, done_e;
        logic pv;
        logic [215:0] held, expw;
        e = 0; rd_i = 0; nwin = 0; ndone = 0; done_e = -1; pv = 1'b0;
        @(negedge clk);
        start = 1'b1; top_row = 2'(t); ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        top_row = 2'(t + 1);
        chk("busy_after_start", busy, 1'b1);
        while (!(ndone > 0 && !busy && !done) && e < 400) begin
            start = (e == busy_edge);
            if (rd_en) begin
                chk("rd_row", row, (t + rd_i % 3) % 3);
                chk("rd_col", column, rd_i / 3);
                rd_i++;
            end
            if (done) begin
                ndone++;
                done_e = e;
            end
            if (valid && !pv) begin
                chk("win_edge", e,
                    12 + 5 * nwin + ((nwin >= 2) ? stall_len : 0));
                chk("center", center, nwin + 1);
                expw = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        expw[(3*r+c)*24 +: 24] = pix((t + r) % 3, nwin + c);
                chk("window", window, expw);
                nwin++;
                if (nwin == 2 && stall_len > 0) begin
                    ready = 1'b0;
                    held = window;
                    for (int s = 0; s < stall_len; s++) begin
                        @(posedge clk);
                        e++;
                        @(negedge clk);
                        chk("stall_valid", valid, 1'b1);
                        chk("stall_window", window, held);
                        chk("stall_center", center, 3'd2);
                        chk("stall_no_read", rd_en, 1'b0);
                    end
                    ready = 1'b1;
                end
            end
            pv = valid;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_count", ndone, 1);
        chk("done_edge", done_e, 38 + stall_len);
        chk("win_count", nwin, 6);
        chk("read_count", rd_i, 24);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int e, rises, nwin, nread, last_rd, bad_rd, last_ctr, done_e;
        logic pv;

        rst = 1'b1; start = 1'b1; top_row = '0; ready = 1'b0;
        w_start = 1'b0; w_top_row = '0; w_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_column", column, 3'd0);
        chk("rst_row", row, 2'd0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_window", window, 216'd0);
        chk("rst_center", center, 3'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0; start = 1'b0; ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_no_busy", busy, 1'b0);
        chk("idle_no_read", rd_en, 1'b0);

        // Full sweep, ready high.
        sweep(0, 0, -1);
        // Row wrap: window rows come from buffer rows 2/0/1.
        sweep(2, 0, -1);
        // Backpressure on the second window.
        sweep(0, 10, -1);
        // Start pulsed mid-sweep is ignored.
        sweep(1, 0, 20);

        // Reset during the third EMIT.
        @(negedge clk);
        start = 1'b1; top_row = 2'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rises = 0; pv = 1'b0; e = 0;
        while (rises < 3 && e < 200) begin
            if (valid && !pv) rises++;
            pv = valid;
            if (rises < 3) begin
                @(posedge clk);
                e++;
                @(negedge clk);
            end
        end
        chk("third_emit_seen", rises, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_column", column, 3'd0);
        chk("mid_rst_row", row, 2'd0);
        chk("mid_rst_rd_en", rd_en, 1'b0);
        chk("mid_rst_window", window, 216'd0);
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        start = 1'b1; top_row = 2'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart_rd_en", rd_en, 1'b1);
        chk("restart_col", column, 3'd0);
        chk("restart_row", row, 2'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 640-column sweep on the wide instance. An out-of-range top
        // row is forced to 0.
        w_start = 1'b1; w_top_row = 2'd3;
        @(posedge clk);
        @(negedge clk);
        w_start = 1'b0;
        e = 0; nwin = 0; nread = 0; last_rd = -1; bad_rd = 0;
        last_ctr = -1; done_e = -1; pv = 1'b0;
        while (done_e < 0 && e < 3400) begin
            if (w_rd_en) begin
                if (last_rd == 639 && int'(w_column) != 639) bad_rd++;
                if (nread % 3 == 0)
                    chk("w_rd_row0", w_row, 2'd0);
                last_rd = int'(w_column);
                nread++;
            end
            if (w_valid && !pv) begin
                nwin++;
                last_ctr = int'(w_center);
            end
            if (w_done) done_e = e;
            pv = w_valid;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        chk("w_done_edge", done_e, 3198);
        chk("w_win_count", nwin, 638);
        chk("w_last_center", last_ctr, 638);
        chk("w_last_rd_col", last_rd, 639);
        chk("w_read_count", nread, 1920);
        chk("w_no_wrap_read", bad_rd, 0);
        chk("w_idle_busy", w_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
